// File: rtl/kmeans_centroid_update_k3_d2_if.sv
// Sample/flush bus and centroid result bus of the k=3, d=2 centroid update block.
interface kmeans_centroid_update_k3_d2_if #(
  parameter int unsigned input_data_width  = 16,
  parameter int unsigned centroid_id_width = 2
);
  logic                          in_valid;
  logic                          in_ready;
  logic [input_data_width-1:0]   in_data0;
  logic [input_data_width-1:0]   in_data1;
  logic [centroid_id_width-1:0]  in_centroid_id;
  logic                          flush;
  logic [input_data_width-1:0]   centroid0_d0, centroid0_d1;
  logic [input_data_width-1:0]   centroid1_d0, centroid1_d1;
  logic [input_data_width-1:0]   centroid2_d0, centroid2_d1;
  logic [input_data_width-1:0]   new_centroid0_d0, new_centroid0_d1;
  logic [input_data_width-1:0]   new_centroid1_d0, new_centroid1_d1;
  logic [input_data_width-1:0]   new_centroid2_d0, new_centroid2_d1;
  logic                          out_valid;
  logic                          count_ovf;

  modport master (
    output in_valid, in_data0, in_data1, in_centroid_id, flush,
           centroid0_d0, centroid0_d1, centroid1_d0, centroid1_d1,
           centroid2_d0, centroid2_d1,
    input  in_ready, new_centroid0_d0, new_centroid0_d1, new_centroid1_d0,
           new_centroid1_d1, new_centroid2_d0, new_centroid2_d1,
           out_valid, count_ovf
  );

  modport slave (
    input  in_valid, in_data0, in_data1, in_centroid_id, flush,
           centroid0_d0, centroid0_d1, centroid1_d0, centroid1_d1,
           centroid2_d0, centroid2_d1,
    output in_ready, new_centroid0_d0, new_centroid0_d1, new_centroid1_d0,
           new_centroid1_d1, new_centroid2_d0, new_centroid2_d1,
           out_valid, count_ovf
  );
endinterface

// File: rtl/kmeans_centroid_update_k3_d2.sv
// Per-centroid sum/count accumulation and sequential mean division for k=3, d=2.
// Optional KMEANS_CENTROID_ROUND_EN selects round-half-up means instead of floor.
module kmeans_centroid_update_k3_d2 #(
  parameter int unsigned input_data_width  = 16,
  parameter int unsigned centroid_id_width = 2,
  parameter int unsigned count_width       = 16
) (
  input logic clk,
  input logic rst,
  kmeans_centroid_update_k3_d2_if.slave bus
);
  localparam int unsigned W     = input_data_width;
  localparam int unsigned CW    = count_width;
  localparam int unsigned ACC_W = W + CW;
  localparam int unsigned BIT_W = $clog2(ACC_W + 1);
`ifdef KMEANS_CENTROID_ROUND_EN
  localparam int unsigned DVD_W = ACC_W + 1;
`else
  localparam int unsigned DVD_W = ACC_W;
`endif

  typedef enum logic [1:0] {ACC, DIV, DONE} state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   sum_q  [3][2];
  logic [CW-1:0]      cnt_q  [3];
  logic [W-1:0]       newc_q [3][2];
  logic [W-1:0]       cin    [3][2];
  logic               ready_q, out_valid_q, ovf_q;
  logic [2:0]         slot_q;
  logic [BIT_W-1:0]   bit_q;
  logic [CW-1:0]      rem_q;
  logic [ACC_W-1:0]   quo_q;
  logic [W-1:0]       hold_q;

  logic [1:0]         k_c;
  logic               d_c;
  logic [CW-1:0]      divisor_c;
  logic [DVD_W-1:0]   dvd_c;
  logic [CW:0]        rem_sh_c;
  logic               ge_c;
  logic [CW-1:0]      rem_nx_c;
  logic [ACC_W-1:0]   quo_nx_c;
  logic [W-1:0]       res_c;
  logic               accept_c;

  assign cin[0][0] = bus.centroid0_d0;  assign cin[0][1] = bus.centroid0_d1;
  assign cin[1][0] = bus.centroid1_d0;  assign cin[1][1] = bus.centroid1_d1;
  assign cin[2][0] = bus.centroid2_d0;  assign cin[2][1] = bus.centroid2_d1;

  assign bus.new_centroid0_d0 = newc_q[0][0];  assign bus.new_centroid0_d1 = newc_q[0][1];
  assign bus.new_centroid1_d0 = newc_q[1][0];  assign bus.new_centroid1_d1 = newc_q[1][1];
  assign bus.new_centroid2_d0 = newc_q[2][0];  assign bus.new_centroid2_d1 = newc_q[2][1];
  assign bus.in_ready  = ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.count_ovf = ovf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ACC;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACC:     if (bus.flush) state_d = DIV;
      DIV:     if (slot_q == 3'd5 && bit_q == BIT_W'(ACC_W)) state_d = DONE;
      DONE:    state_d = ACC;
      default: state_d = ACC;
    endcase
  end

  // One restoring-division step on the current slot; slot index = 2*k + d.
  always_comb begin
    k_c       = slot_q[2:1];
    d_c       = slot_q[0];
    divisor_c = cnt_q[k_c];
`ifdef KMEANS_CENTROID_ROUND_EN
    dvd_c     = {1'b0, sum_q[k_c][d_c]} + DVD_W'(cnt_q[k_c] >> 1);
`else
    dvd_c     = sum_q[k_c][d_c];
`endif
    rem_sh_c  = {rem_q, quo_q[ACC_W-1]};
    ge_c      = rem_sh_c >= {1'b0, divisor_c};
    rem_nx_c  = ge_c ? (rem_sh_c[CW-1:0] - divisor_c) : rem_sh_c[CW-1:0];
    quo_nx_c  = {quo_q[ACC_W-2:0], ge_c};
`ifdef KMEANS_CENTROID_ROUND_EN
    res_c     = (|quo_nx_c[ACC_W-1:W]) ? {W{1'b1}} : quo_nx_c[W-1:0];
`else
    res_c     = quo_nx_c[W-1:0];
`endif
    accept_c  = bus.in_valid && ready_q && (32'(bus.in_centroid_id) < 32'd3);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= '0;
        for (int j = 0; j < 2; j++) begin
          sum_q[i][j]  <= '0;
          newc_q[i][j] <= '0;
        end
      end
      ready_q     <= 1'b1;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      slot_q      <= '0;
      bit_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      hold_q      <= '0;
    end else begin
      out_valid_q <= 1'b0;
      ready_q     <= (state_d == ACC);
      case (state_q)
        ACC: begin
          slot_q <= '0;
          bit_q  <= '0;
          if (accept_c) begin
            // A saturated counter drops the sample so the sum stays consistent with the count.
            if (&cnt_q[bus.in_centroid_id]) begin
              ovf_q <= 1'b1;
            end else begin
              sum_q[bus.in_centroid_id][0] <= sum_q[bus.in_centroid_id][0] + ACC_W'(bus.in_data0);
              sum_q[bus.in_centroid_id][1] <= sum_q[bus.in_centroid_id][1] + ACC_W'(bus.in_data1);
              cnt_q[bus.in_centroid_id]    <= cnt_q[bus.in_centroid_id] + CW'(1);
            end
          end
        end
        DIV: begin
          if (bit_q == '0) begin
            // The rounded dividend's top bit seeds the remainder; its quotient bit is always 0.
`ifdef KMEANS_CENTROID_ROUND_EN
            rem_q <= CW'(dvd_c[ACC_W]);
            quo_q <= dvd_c[ACC_W-1:0];
`else
            rem_q <= '0;
            quo_q <= dvd_c;
`endif
            hold_q <= cin[k_c][d_c];
            bit_q  <= BIT_W'(1);
          end else begin
            rem_q <= rem_nx_c;
            quo_q <= quo_nx_c;
            if (bit_q == BIT_W'(ACC_W)) begin
              newc_q[k_c][d_c] <= (divisor_c == '0) ? hold_q : res_c;
              bit_q            <= '0;
              slot_q           <= slot_q + 3'd1;
            end else begin
              bit_q <= bit_q + BIT_W'(1);
            end
          end
        end
        DONE: begin
          out_valid_q <= 1'b1;
          ovf_q       <= 1'b0;
          for (int i = 0; i < 3; i++) begin
            cnt_q[i] <= '0;
            for (int j = 0; j < 2; j++) sum_q[i][j] <= '0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_kmeans_centroid_update_k3_d2.sv
// Directed bench for kmeans_centroid_update_k3_d2: default instance plus a count_width=2 instance.
module tb_kmeans_centroid_update_k3_d2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  kmeans_centroid_update_k3_d2_if #(.input_data_width(16), .centroid_id_width(2)) b1 ();
  kmeans_centroid_update_k3_d2_if #(.input_data_width(16), .centroid_id_width(2)) b2 ();

  kmeans_centroid_update_k3_d2 #(.input_data_width(16), .centroid_id_width(2), .count_width(16))
    dut (.clk(clk), .rst(rst), .bus(b1));
  kmeans_centroid_update_k3_d2 #(.input_data_width(16), .centroid_id_width(2), .count_width(2))
    dut_small (.clk(clk), .rst(rst), .bus(b2));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cin(input logic [15:0] a0, a1, c0, c1, e0, e1);
    b1.centroid0_d0 = a0; b1.centroid0_d1 = a1;
    b1.centroid1_d0 = c0; b1.centroid1_d1 = c1;
    b1.centroid2_d0 = e0; b1.centroid2_d1 = e1;
  endtask

  task automatic send(input logic [15:0] x, y, input logic [1:0] id);
    b1.in_valid = 1'b1; b1.in_data0 = x; b1.in_data1 = y; b1.in_centroid_id = id;
    tick();
    b1.in_valid = 1'b0;
  endtask

  task automatic send2(input logic [15:0] x, y, input logic [1:0] id);
    b2.in_valid = 1'b1; b2.in_data0 = x; b2.in_data1 = y; b2.in_centroid_id = id;
    tick();
    b2.in_valid = 1'b0;
  endtask

  task automatic wait_done(input bit sel, input int exp, input string tag);
    int  n    = 0;
    bit  seen = 1'b0;
    while (!seen && n < 400) begin
      tick();
      n++;
      seen = sel ? b2.out_valid : b1.out_valid;
    end
    check(tag, n, exp);
  endtask

  task automatic check_c(input string tag, input logic [15:0] e00, e01, e10, e11, e20, e21);
    check({tag, "_c0d0"}, 32'(b1.new_centroid0_d0), 32'(e00));
    check({tag, "_c0d1"}, 32'(b1.new_centroid0_d1), 32'(e01));
    check({tag, "_c1d0"}, 32'(b1.new_centroid1_d0), 32'(e10));
    check({tag, "_c1d1"}, 32'(b1.new_centroid1_d1), 32'(e11));
    check({tag, "_c2d0"}, 32'(b1.new_centroid2_d0), 32'(e20));
    check({tag, "_c2d1"}, 32'(b1.new_centroid2_d1), 32'(e21));
  endtask

  initial begin
    int ov_cnt;
    b1.in_valid = 1'b0; b1.in_data0 = '0; b1.in_data1 = '0; b1.in_centroid_id = '0; b1.flush = 1'b0;
    b2.in_valid = 1'b0; b2.in_data0 = '0; b2.in_data1 = '0; b2.in_centroid_id = '0; b2.flush = 1'b0;
    b2.centroid0_d0 = 16'd3; b2.centroid0_d1 = 16'd3; b2.centroid1_d0 = 16'd3;
    b2.centroid1_d1 = 16'd3; b2.centroid2_d0 = 16'd3; b2.centroid2_d1 = 16'd3;
    set_cin(16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0);

    // Reset state
    tick(); tick();
    rst = 1'b0;
    tick();
    check_c("rst", 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0);
    check("rst_out_valid", 32'(b1.out_valid), 32'd0);
    check("rst_in_ready", 32'(b1.in_ready), 32'd1);
    check("rst_count_ovf", 32'(b1.count_ovf), 32'd0);

    // Basic means, empty cluster falls back to centroid input, latency
    set_cin(16'd77, 16'd77, 16'd77, 16'd77, 16'd100, 16'd200);
    send(16'd10, 16'd20, 2'd0);
    send(16'd20, 16'd40, 2'd0);
    send(16'd7, 16'd9, 2'd1);
    b1.flush = 1'b1;
    tick();
    b1.flush = 1'b0;
    check("t1_ready_low", 32'(b1.in_ready), 32'd0);
    wait_done(1'b0, 199, "t1_latency");
    check_c("t1", 16'd15, 16'd30, 16'd7, 16'd9, 16'd100, 16'd200);
    check("t1_ready_back", 32'(b1.in_ready), 32'd1);
    tick();
    check("t1_pulse_end", 32'(b1.out_valid), 32'd0);

    // Floor vs round-half-up
    set_cin(16'd5, 16'd6, 16'd11, 16'd12, 16'd21, 16'd22);
    send(16'd1, 16'd2, 2'd0);
    send(16'd2, 16'd3, 2'd0);
    b1.flush = 1'b1;
    tick();
    b1.flush = 1'b0;
    wait_done(1'b0, 199, "t2_latency");
`ifdef KMEANS_CENTROID_ROUND_EN
    check_c("t2", 16'd2, 16'd3, 16'd11, 16'd12, 16'd21, 16'd22);
`else
    check_c("t2", 16'd1, 16'd2, 16'd11, 16'd12, 16'd21, 16'd22);
`endif

    // id 3 ignored, sample with flush included, samples during DIV lost
    set_cin(16'd31, 16'd32, 16'd41, 16'd42, 16'd1, 16'd1);
    send(16'd500, 16'd500, 2'd3);
    b1.in_valid = 1'b1; b1.in_data0 = 16'd50; b1.in_data1 = 16'd60; b1.in_centroid_id = 2'd2;
    b1.flush = 1'b1;
    tick();
    b1.flush = 1'b0;
    b1.in_data0 = 16'd999; b1.in_data1 = 16'd999;
    for (int i = 0; i < 5; i++) begin
      check("t3_ready_div", 32'(b1.in_ready), 32'd0);
      tick();
    end
    b1.in_valid = 1'b0;
    wait_done(1'b0, 194, "t3_latency");
    check_c("t3", 16'd31, 16'd32, 16'd41, 16'd42, 16'd50, 16'd60);

    // Reset in the middle of DIV
    send(16'd9, 16'd9, 2'd1);
    b1.flush = 1'b1;
    tick();
    b1.flush = 1'b0;
    repeat (100) tick();
    #2 rst = 1'b1;
    #1;
    check_c("t4_rst", 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0);
    check("t4_rst_ready", 32'(b1.in_ready), 32'd1);
    check("t4_rst_out_valid", 32'(b1.out_valid), 32'd0);
    tick();
    rst = 1'b0;
    ov_cnt = 0;
    for (int i = 0; i < 210; i++) begin
      tick();
      if (b1.out_valid) ov_cnt++;
    end
    check("t4_no_out_valid", 32'(ov_cnt), 32'd0);
    set_cin(16'd13, 16'd14, 16'd15, 16'd16, 16'd17, 16'd18);
    send(16'd4, 16'd4, 2'd1);
    b1.flush = 1'b1;
    tick();
    b1.flush = 1'b0;
    wait_done(1'b0, 199, "t4_latency");
    check_c("t4", 16'd13, 16'd14, 16'd4, 16'd4, 16'd17, 16'd18);

    // Counter saturation on the count_width=2 instance
    for (int i = 0; i < 4; i++) begin
      send2(16'd8, 16'd8, 2'd0);
      check($sformatf("t5_ovf_after_%0d", i + 1), 32'(b2.count_ovf), (i == 3) ? 32'd1 : 32'd0);
    end
    b2.flush = 1'b1;
    tick();
    b2.flush = 1'b0;
    check("t5_ovf_in_div", 32'(b2.count_ovf), 32'd1);
    wait_done(1'b1, 115, "t5_latency");
    check("t5_c0d0", 32'(b2.new_centroid0_d0), 32'd8);
    check("t5_c0d1", 32'(b2.new_centroid0_d1), 32'd8);
    check("t5_c1d0", 32'(b2.new_centroid1_d0), 32'd3);
    check("t5_ovf_cleared", 32'(b2.count_ovf), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/kmeans_centroid_update_k3_d2.md
Name: kmeans_centroid_update_k3_d2

Overview:
- Sits directly downstream of the k=3, d=2 distance/assignment pipeline and consumes its per-sample output: the point in two dimensions plus the selected centroid index.
- Accumulates per-centroid coordinate sums and member counts across one iteration.
- On a flush it computes the new centroid coordinates (sum / count) with a shared sequential divider and presents them for the next iteration.

Parameters:
- input_data_width, 16, width of each point coordinate and centroid coordinate (unsigned).
- centroid_id_width, 2, width of the centroid index.
- count_width, 16, width of each per-centroid member counter.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  sample present this cycle.
- in_ready  output  1  block accepts samples; high only in state ACC.
- in_data0  input  input_data_width  sample dimension 0.
- in_data1  input  input_data_width  sample dimension 1.
- in_centroid_id  input  centroid_id_width  assigned centroid, 0..2.
- flush  input  1  end of iteration; start division.
- centroidK_dD (K=0..2, D=0..1)  input  input_data_width  current centroids; used for empty clusters.
- new_centroidK_dD (K=0..2, D=0..1)  output reg  input_data_width  updated centroids.
- out_valid  output reg  1  one-cycle pulse when all new_centroid outputs are updated.
- count_ovf  output reg  1  sticky: a counter saturated this iteration.

Behaviour:
- ACC_W = input_data_width + count_width; sum registers are ACC_W wide and cannot overflow before their count saturates.
- Reset (async): all sums, counts, new_centroid outputs, out_valid and count_ovf are 0; state ACC; in_ready 1 (registered).
- States: ACC, DIV, DONE.
- ACC:
  - Sample accepted when in_valid && in_ready.
  - On accept: sum[id][0] += in_data0, sum[id][1] += in_data1, count[id] += 1.
  - in_centroid_id = 3 is ignored: no update.
  - If count[id] is already all-ones, the sample is dropped and count_ovf is set.
- ACC -> DIV when flush is sampled in ACC; in_ready falls the next cycle.
  - in_valid together with flush: that sample is accumulated first, then it is included in the division.
  - flush outside ACC is ignored.
- DIV:
  - Six quotients in fixed order k0d0, k0d1, k1d0, k1d1, k2d0, k2d1.
  - Each takes 1 load cycle + ACC_W restoring-division iterations (one quotient bit per cycle), unsigned.
  - Total 6*(ACC_W+1) cycles; 198 at defaults.
  - If count[k] = 0, the quotient slot still consumes its cycles, but the result is centroidK_dD sampled at the load cycle.
  - Otherwise result = quotient truncated to input_data_width. The mean never exceeds the input max, so the truncation is lossless.
  - Results are written to the new_centroid registers as each quotient completes.
- DIV -> DONE after the last quotient.
  - DONE lasts 1 cycle: out_valid = 1, sums and counts cleared, count_ovf cleared.
  - Next state ACC; in_ready returns high the cycle after DONE.
- Latency: flush sampled at edge E -> out_valid high after edge E + 6*(ACC_W+1) + 1 (199 at defaults).
- new_centroid outputs hold their values until the next DIV overwrites them.
- in_valid while in_ready is 0: the sample is lost; upstream must stall.
- Reset mid-DIV: immediate return to reset values; no partial out_valid.

Optional Feature:
- Macro KMEANS_CENTROID_ROUND_EN.
  - Defined: the dividend is sum + (count >> 1), giving round-half-up mean. The dividend register gains 1 bit. The result saturates to the all-ones input maximum if rounding would exceed it.
  - Undefined: plain truncating division (floor).
- Latency is identical in both builds.

Test Plan:
- Reset, then check idle state -> all new_centroid = 0, out_valid = 0, in_ready = 1, count_ovf = 0.
- Accept (10,20) id0, (20,40) id0, (7,9) id1, then flush with centroid2 inputs = (100,200) -> out_valid exactly 199 cycles after the flush edge; new_centroid0 = (15,30), new_centroid1 = (7,9), new_centroid2 = (100,200) (empty cluster).
- Accept (1,2) id0 and (2,3) id0 -> without the macro new_centroid0 = (1,2); with KMEANS_CENTROID_ROUND_EN new_centroid0 = (2,3).
- in_valid with sample (50,60) id2 in the same cycle as flush -> sample included, new_centroid2 = (50,60). Any in_valid during DIV is not accepted and in_ready = 0.
- Assert rst at cycle 100 of DIV -> no out_valid, outputs 0, in_ready 1. The next iteration with (4,4) id1 gives new_centroid1 = (4,4) and no residue from the old sums.
- Force count_width = 2, send 4 samples of (8,8) to id0 -> count_ovf = 1 after the 4th sample, new_centroid0 = (8,8), and count_ovf clears in DONE.
